// File: rtl/mult_stream_sequencer.sv
// Streams operand read addresses around a pipelined multiplier and replays them,
// LATENCY cycles later, as result-RAM write enables/addresses; multi-pass, abort, lock supervision.
module mult_stream_sequencer #(
    parameter int ADDR_WIDTH = 9,
    parameter int LATENCY    = 8,
    parameter int LOOP_WIDTH = 16
) (
    input  logic                  pll_clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  pll_lock,
    input  logic [ADDR_WIDTH-1:0] cfg_first,
    input  logic [ADDR_WIDTH-1:0] cfg_last,
    input  logic [LOOP_WIDTH-1:0] cfg_loops,
    output logic                  r_en,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  lock_err,
    output logic [31:0]           cycle_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   first_q;
    logic [ADDR_WIDTH-1:0]   last_q;
    logic [LOOP_WIDTH-1:0]   loops_left;
    logic [LATENCY-1:0]      dly_vld;
    logic [LATENCY-1:0]      vld_shift;
    logic [ADDR_WIDTH-1:0]   dly_addr [LATENCY];
    logic                    lock_lost;

    assign lock_lost = ((state == S_RUN) || (state == S_DRAIN)) && !pll_lock;

    // Next contents of the valid chain; DRAIN ends once nothing valid survives this shift.
    always_comb begin
        vld_shift    = dly_vld;
        vld_shift[0] = r_en;
        for (int i = 1; i < LATENCY; i++) begin
            vld_shift[i] = dly_vld[i-1];
        end
    end

    always_ff @(posedge pll_clock) begin
        if (!resetn || lock_lost) begin
            dly_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dly_addr[i] <= '0;
            end
        end else begin
            dly_vld     <= vld_shift;
            dly_addr[0] <= r_addr;
            for (int i = 1; i < LATENCY; i++) begin
                dly_addr[i] <= dly_addr[i-1];
            end
        end
    end

    assign we     = dly_vld[LATENCY-1];
    assign w_addr = dly_addr[LATENCY-1];

    always_ff @(posedge pll_clock) begin
        if (!resetn) begin
            state       <= S_IDLE;
            first_q     <= '0;
            last_q      <= '0;
            loops_left  <= '0;
            r_en        <= 1'b0;
            r_addr      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            lock_err    <= 1'b0;
            cycle_count <= '0;
        end else begin
            if (busy && (cycle_count != 32'hFFFF_FFFF)) begin
                cycle_count <= cycle_count + 32'd1;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (pll_lock) begin
                            first_q     <= cfg_first;
                            last_q      <= cfg_last;
                            loops_left  <= (cfg_loops == '0) ? LOOP_WIDTH'(1) : cfg_loops;
                            done        <= 1'b0;
                            lock_err    <= 1'b0;
                            cycle_count <= '0;
                            r_en        <= 1'b1;
                            r_addr      <= cfg_first;
                            busy        <= 1'b1;
                            state       <= S_RUN;
                        end else begin
                            lock_err <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                end
                S_RUN: begin
                    if (!pll_lock) begin
                        lock_err <= 1'b1;
                        done     <= 1'b0;
                        busy     <= 1'b0;
                        r_en     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (abort || ((r_addr == last_q) && (loops_left == LOOP_WIDTH'(1)))) begin
                        r_en  <= 1'b0;
                        state <= S_DRAIN;
                    end else if (r_addr == last_q) begin
                        loops_left <= loops_left - 1'b1;
                        r_addr     <= first_q;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!pll_lock) begin
                        lock_err <= 1'b1;
                        done     <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (!(|vld_shift)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_stream_sequencer.sv
// Directed bench for mult_stream_sequencer: hand-written address sequences checked cycle by cycle.
module tb_mult_stream_sequencer;

    localparam int AW  = 9;
    localparam int LAT = 8;
    localparam int LW  = 16;

    logic          pll_clock = 1'b0;
    logic          resetn;
    logic          start;
    logic          abort;
    logic          pll_lock;
    logic [AW-1:0] cfg_first;
    logic [AW-1:0] cfg_last;
    logic [LW-1:0] cfg_loops;
    logic          r_en;
    logic [AW-1:0] r_addr;
    logic          we;
    logic [AW-1:0] w_addr;
    logic          busy;
    logic          done;
    logic          lock_err;
    logic [31:0]   cycle_count;

    int vectors = 0;
    int errors  = 0;
    int exp_q[$];

    mult_stream_sequencer #(.ADDR_WIDTH(AW), .LATENCY(LAT), .LOOP_WIDTH(LW)) dut (
        .pll_clock(pll_clock), .resetn(resetn), .start(start), .abort(abort),
        .pll_lock(pll_lock), .cfg_first(cfg_first), .cfg_last(cfg_last),
        .cfg_loops(cfg_loops), .r_en(r_en), .r_addr(r_addr), .we(we),
        .w_addr(w_addr), .busy(busy), .done(done), .lock_err(lock_err),
        .cycle_count(cycle_count)
    );

    always #5 pll_clock = ~pll_clock;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pll_clock);
        #1;
    endtask

    // Run one configuration from IDLE/DONE; exp_q holds the expected read (and write) addresses.
    task automatic run(input string tag, input logic [AW-1:0] f, input logic [AW-1:0] l,
                       input logic [LW-1:0] lp, input int abort_c, input int restart_c);
        int n;
        n = exp_q.size();
        cfg_first = f;
        cfg_last  = l;
        cfg_loops = lp;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= n + LAT + 1; c++) begin
            chk({tag, ".r_en"}, 32'(r_en), 32'(c <= n));
            if (c <= n) chk({tag, ".r_addr"}, 32'(r_addr), exp_q[c-1]);
            chk({tag, ".we"}, 32'(we), 32'((c > LAT) && (c <= n + LAT)));
            if ((c > LAT) && (c <= n + LAT)) chk({tag, ".w_addr"}, 32'(w_addr), exp_q[c-1-LAT]);
            chk({tag, ".busy"}, 32'(busy), 32'(c <= n + LAT));
            chk({tag, ".done"}, 32'(done), 32'(c == n + LAT + 1));
            abort = (c == abort_c);
            if (c == restart_c) begin
                start     = 1'b1;
                cfg_first = 9'd100;
                cfg_last  = 9'd100;
                cfg_loops = 16'd5;
            end else begin
                start = 1'b0;
            end
            if (c < n + LAT + 1) step();
        end
        chk({tag, ".cycle_count"}, cycle_count, 32'(n + LAT));
        chk({tag, ".lock_err"}, 32'(lock_err), 32'd0);
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".r_en"}, 32'(r_en), 32'd0);
        chk({tag, ".r_addr"}, 32'(r_addr), 32'd0);
        chk({tag, ".we"}, 32'(we), 32'd0);
        chk({tag, ".w_addr"}, 32'(w_addr), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".lock_err"}, 32'(lock_err), 32'd0);
        chk({tag, ".cycle_count"}, cycle_count, 32'd0);
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        pll_lock  = 1'b1;
        cfg_first = '0;
        cfg_last  = '0;
        cfg_loops = '0;
        step();
        step();
        chk_all_zero("reset");
        resetn = 1'b1;
        step();

        exp_q = {0, 1, 2, 3};
        run("basic", 9'd0, 9'd3, 16'd1, -1, -1);

        exp_q = {510, 511, 0, 1, 510, 511, 0, 1};
        run("wrap", 9'd510, 9'd1, 16'd2, -1, -1);

        exp_q = {5};
        run("single", 9'd5, 9'd5, 16'd0, -1, -1);

        exp_q = {};
        for (int i = 0; i <= 8; i++) exp_q.push_back(i);
        run("abort", 9'd0, 9'd99, 16'd1, 9, -1);

        // Lock loss mid-run: writes in flight are discarded.
        cfg_first = 9'd0;
        cfg_last  = 9'd99;
        cfg_loops = 16'd1;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk("lock.r_en", 32'(r_en), 32'd1);
            chk("lock.r_addr", 32'(r_addr), 32'(c - 1));
            if (c == 5) pll_lock = 1'b0;
            step();
        end
        chk("lock.lock_err", 32'(lock_err), 32'd1);
        chk("lock.busy", 32'(busy), 32'd0);
        chk("lock.done", 32'(done), 32'd0);
        chk("lock.r_en_off", 32'(r_en), 32'd0);
        for (int c = 6; c <= 16; c++) begin
            chk("lock.we", 32'(we), 32'd0);
            start = (c == 10);
            step();
        end
        chk("refused.lock_err", 32'(lock_err), 32'd1);
        chk("refused.busy", 32'(busy), 32'd0);
        chk("refused.r_en", 32'(r_en), 32'd0);
        start    = 1'b0;
        pll_lock = 1'b1;
        step();

        exp_q = {0, 1, 2, 3};
        run("busy_start", 9'd0, 9'd3, 16'd1, -1, 2);
        exp_q = {7, 8, 9};
        run("rerun", 9'd7, 9'd9, 16'd1, -1, -1);

        // Reset while draining.
        cfg_first = 9'd0;
        cfg_last  = 9'd3;
        cfg_loops = 16'd1;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 6) resetn = 1'b0;
            step();
        end
        chk_all_zero("rst_drain");
        resetn = 1'b1;
        for (int c = 8; c <= 14; c++) begin
            step();
            chk("rst_drain.we_after", 32'(we), 32'd0);
            chk("rst_drain.busy_after", 32'(busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
